// File: rtl/usb_sl811_arb.sv
// Two-port arbiter that serialises register accesses onto an SL811 host controller bus.
// Optional SL811_ROUND_ROBIN_EN selects round-robin grant on ties; default is fixed priority to port 0.
module usb_sl811_arb #(
  parameter int STROBE_CYCLES = 4
) (
  input  logic       clk_bus,
  input  logic       rst,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata1,
  output logic       sl811_a0,
  output logic [7:0] sl811_dout,
  output logic       sl811_doe,
  input  logic [7:0] sl811_din,
  output logic       sl811_cs_n,
  output logic       sl811_we_n,
  output logic       sl811_rd_n,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a request, bus released
  // ADDR  | register index driven with a0=0 under a write strobe
  // GAP   | one cycle with every strobe released between phases
  // DATA  | a0=1, write data driven or read strobe asserted
  // DONE  | strobes released, ack pulse to the granted port
  typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       gnt;
  logic       lat_we;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic       any_req;
  logic       pick;

`ifdef SL811_ROUND_ROBIN_EN
  logic last_gnt;

  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 && req1) ? ~last_gnt : ~req0;
  end
`else
  always_comb begin
    any_req = req0 | req1;
    pick    = ~req0;
  end
`endif

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      sl811_cs_n <= 1'b1;
      sl811_we_n <= 1'b1;
      sl811_rd_n <= 1'b1;
      sl811_a0   <= 1'b0;
      sl811_doe  <= 1'b0;
      sl811_dout <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
`ifdef SL811_ROUND_ROBIN_EN
      last_gnt   <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ADDR;
            cnt        <= CNT_LOAD;
            gnt        <= pick;
            lat_we     <= pick ? we1 : we0;
            lat_addr   <= pick ? addr1 : addr0;
            lat_wdata  <= pick ? wdata1 : wdata0;
            sl811_cs_n <= 1'b0;
            sl811_we_n <= 1'b0;
            sl811_rd_n <= 1'b1;
            sl811_a0   <= 1'b0;
            sl811_doe  <= 1'b1;
            sl811_dout <= pick ? addr1 : addr0;
            busy       <= 1'b1;
`ifdef SL811_ROUND_ROBIN_EN
            last_gnt   <= pick;
`endif
          end
        end
        ADDR: begin
          if (cnt == 4'd0) begin
            state      <= GAP;
            sl811_cs_n <= 1'b1;
            sl811_we_n <= 1'b1;
            sl811_doe  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          state      <= DATA;
          cnt        <= CNT_LOAD;
          sl811_cs_n <= 1'b0;
          sl811_a0   <= 1'b1;
          if (lat_we) begin
            sl811_we_n <= 1'b0;
            sl811_doe  <= 1'b1;
            sl811_dout <= lat_wdata;
          end else begin
            sl811_rd_n <= 1'b0;
          end
        end
        DATA: begin
          if (cnt == 4'd0) begin
            state      <= DONE;
            sl811_cs_n <= 1'b1;
            sl811_we_n <= 1'b1;
            sl811_rd_n <= 1'b1;
            sl811_doe  <= 1'b0;
            // read data is captured on the edge that ends the read strobe
            if (!lat_we) begin
              if (gnt) rdata1 <= sl811_din;
              else     rdata0 <= sl811_din;
            end
            if (gnt) ack1 <= 1'b1;
            else     ack0 <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_sl811_arb.sv
// Scoreboard bench for usb_sl811_arb: stimulus queues expected acks, a monitor checks bus phases and acks.
// A second instance with STROBE_CYCLES=1 covers the minimum strobe width.
module tb_usb_sl811_arb;
  localparam int S = 4;

  logic clk_bus = 1'b0;
  logic rst;
  logic req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1, sl811_din;
  logic ack0, ack1, sl811_a0, sl811_doe, sl811_cs_n, sl811_we_n, sl811_rd_n, busy;
  logic [7:0] rdata0, rdata1, sl811_dout;

  logic s1_req0;
  logic s1_ack0, s1_ack1, s1_a0, s1_doe, s1_cs_n, s1_we_n, s1_rd_n, s1_busy;
  logic [7:0] s1_rdata0, s1_rdata1, s1_dout;

  always #5 clk_bus = ~clk_bus;

  usb_sl811_arb #(.STROBE_CYCLES(S)) dut (
    .clk_bus(clk_bus), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .sl811_a0(sl811_a0), .sl811_dout(sl811_dout), .sl811_doe(sl811_doe), .sl811_din(sl811_din),
    .sl811_cs_n(sl811_cs_n), .sl811_we_n(sl811_we_n), .sl811_rd_n(sl811_rd_n), .busy(busy)
  );

  usb_sl811_arb #(.STROBE_CYCLES(1)) dut1 (
    .clk_bus(clk_bus), .rst(rst),
    .req0(s1_req0), .we0(1'b1), .addr0(8'h0E), .wdata0(8'h99), .ack0(s1_ack0), .rdata0(s1_rdata0),
    .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00), .ack1(s1_ack1), .rdata1(s1_rdata1),
    .sl811_a0(s1_a0), .sl811_dout(s1_dout), .sl811_doe(s1_doe), .sl811_din(8'h00),
    .sl811_cs_n(s1_cs_n), .sl811_we_n(s1_we_n), .sl811_rd_n(s1_rd_n), .busy(s1_busy)
  );

  typedef struct {
    bit         p;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         ack_cyc;
  } item_t;

  item_t exp_q[$];
  int    s1_q[$];
  logic [7:0] mdl_rdata [2];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_addr = 0, n_gap = 0, n_data = 0;

  always @(posedge clk_bus) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: bus protocol every cycle, phase shape while busy, scoreboard pop on ack
  always @(negedge clk_bus) begin
    item_t it;
    if (rst) begin
      n_addr = 0; n_gap = 0; n_data = 0;
    end else begin
      chk("we_rd_overlap", {1'b0, ~sl811_we_n & ~sl811_rd_n}, 0);
      chk("doe_during_rd", {1'b0, sl811_doe & ~sl811_rd_n}, 0);
      chk("s1_we_rd_overlap", {1'b0, ~s1_we_n & ~s1_rd_n}, 0);
      chk("s1_doe_during_rd", {1'b0, s1_doe & ~s1_rd_n}, 0);
      if (ack0 | ack1) begin
        chk("ack_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          it = exp_q.pop_front();
          chk("ack_both", {31'd0, ack0 & ack1}, 0);
          chk("ack_port", {31'd0, ack1}, {31'd0, it.p});
          chk("ack_cycle", cyc, it.ack_cyc);
          chk("rdata", it.p ? rdata1 : rdata0, it.rdata);
          chk("addr_len", n_addr, S);
          chk("gap_len", n_gap, 1);
          chk("data_len", n_data, S);
        end
        n_addr = 0; n_gap = 0; n_data = 0;
      end else if (busy && exp_q.size() != 0) begin
        it = exp_q[0];
        if (!sl811_cs_n && !sl811_a0) begin
          n_addr++;
          chk("addr_phase", {sl811_dout, sl811_we_n, sl811_rd_n, sl811_doe}, {it.addr, 3'b011});
        end else if (!sl811_cs_n && sl811_a0) begin
          n_data++;
          if (it.we)
            chk("wr_data_phase", {sl811_dout, sl811_we_n, sl811_rd_n, sl811_doe}, {it.wdata, 3'b011});
          else
            chk("rd_data_phase", {sl811_we_n, sl811_rd_n, sl811_doe}, 3'b100);
        end else begin
          n_gap++;
        end
      end
      if (s1_ack0 | s1_ack1) begin
        chk("s1_ack_expected", {31'd0, s1_q.size() != 0}, 1);
        chk("s1_ack_port", {30'd0, s1_ack1, s1_ack0}, 1);
        if (s1_q.size() != 0) chk("s1_ack_cycle", cyc, s1_q.pop_front());
      end
    end
  end

  task automatic set_port(input bit p, input bit rq, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (p) begin req1 = rq; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = rq; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic issue(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] din_v, input bit drop_gap);
    item_t it;
    int k;
    bit got;
    @(negedge clk_bus);
    set_port(p, 1'b1, we, a, d);
    sl811_din = ~din_v;
    k = cyc + 1;
    if (!we) mdl_rdata[p] = din_v;
    it = '{p: p, we: we, addr: a, wdata: d, rdata: mdl_rdata[p], ack_cyc: k + 2*S + 1};
    exp_q.push_back(it);
    got = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_bus);
      if (drop_gap && cyc == k + S) set_port(p, 1'b0, we, a, d);
      if (cyc == k + 2*S) sl811_din = din_v;
      if (p ? ack1 : ack0) begin got = 1; break; end
    end
    chk("ack_timeout", {31'd0, got}, 1);
    if (!got) exp_q.delete();
    set_port(p, 1'b0, we, a, d);
  endtask

  initial begin
    int k, acks, c;
    bit got;
    item_t it;
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    sl811_din = 0; s1_req0 = 0;
    mdl_rdata[0] = 0; mdl_rdata[1] = 0;
    repeat (3) @(posedge clk_bus);
    #1;
    chk("rst_strobes", {sl811_cs_n, sl811_we_n, sl811_rd_n, sl811_doe, sl811_a0}, 5'b11100);
    chk("rst_misc", {sl811_dout, rdata0, rdata1, ack0, ack1, busy}, 0);
    #1 rst = 1'b0;

    issue(0, 1, 8'h05, 8'hA5, 8'h00, 0);   // basic write
    issue(1, 0, 8'h0D, 8'h00, 8'h3C, 0);   // read on port 1
    issue(0, 0, 8'h0F, 8'h00, 8'h77, 0);   // read on port 0, din valid only in last DATA cycle
    issue(1, 1, 8'h21, 8'h5E, 8'h00, 0);   // write keeps rdata1
    issue(0, 1, 8'h06, 8'hC3, 8'h00, 1);   // requester drops req in GAP

    // reset during DATA of a write aborts with no ack
    @(negedge clk_bus);
    set_port(0, 1'b1, 1'b1, 8'h22, 8'h5A);
    c = cyc;
    it = '{p: 0, we: 1, addr: 8'h22, wdata: 8'h5A, rdata: mdl_rdata[0], ack_cyc: c + 2*S + 2};
    exp_q.push_back(it);
    while (cyc < c + S + 3) @(negedge clk_bus);
    chk("in_data_phase", {sl811_cs_n, sl811_a0}, 2'b01);
    @(posedge clk_bus);
    #2 rst = 1'b1;
    #1;
    chk("abort_strobes", {sl811_cs_n, sl811_we_n, sl811_rd_n, sl811_doe}, 4'b1110);
    chk("abort_misc", {ack0, ack1, busy, rdata0, sl811_dout}, 0);
    exp_q.delete();
    mdl_rdata[0] = 0; mdl_rdata[1] = 0;
    set_port(0, 1'b0, 1'b1, 8'h22, 8'h5A);
    repeat (3) @(posedge clk_bus);
    #2 rst = 1'b0;

    // contention with both requests held for four transactions
    @(negedge clk_bus);
    set_port(0, 1'b1, 1'b1, 8'h40, 8'h01);
    set_port(1, 1'b1, 1'b1, 8'h41, 8'h02);
    k = cyc + 1;
    for (int i = 0; i < 4; i++) begin
`ifdef SL811_ROUND_ROBIN_EN
      it.p = i[0];
`else
      it.p = 1'b0;
`endif
      it.we = 1'b1;
      it.addr = it.p ? 8'h41 : 8'h40;
      it.wdata = it.p ? 8'h02 : 8'h01;
      it.rdata = 8'h00;
      it.ack_cyc = k + 2*S + 1 + i*(2*S + 3);
      exp_q.push_back(it);
    end
    acks = 0;
    for (int n = 0; n < 120 && acks < 4; n++) begin
      @(negedge clk_bus);
      if (ack0 | ack1) acks++;
    end
    chk("contention_acks", acks, 4);
    set_port(0, 1'b0, 1'b1, 8'h40, 8'h01);
    set_port(1, 1'b0, 1'b1, 8'h41, 8'h02);
    repeat (3) @(negedge clk_bus);
    chk("contention_drained", exp_q.size(), 0);
    exp_q.delete();

    // single write with STROBE_CYCLES=1
    @(negedge clk_bus);
    s1_req0 = 1'b1;
    s1_q.push_back(cyc + 4);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_bus);
      if (s1_ack0) begin got = 1; break; end
    end
    chk("s1_ack_timeout", {31'd0, got}, 1);
    s1_req0 = 1'b0;
    repeat (3) @(negedge clk_bus);
    chk("s1_drained", s1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
